multi_stopwatch: RTL and testbench

Parametrised N-channel stopwatch core: NUM_CH independent BCD stopwatches share one tick prescaler, one debounced button set, and a shared lap buffer. A toggle pulse rotates the selected channel. The core outputs the selected channel's display value and the lap buffer read-out. It sits between the Debouncer instances and Seg_7_Display, replacing the fixed two-stopwatch top-level wiring.

---
 rtl/stopwatch_pkg.sv | 43 ++++
 rtl/sw_channel.sv | 74 +++++++
 rtl/multi_stopwatch.sv | 154 +++++++++++++++
 tb/tb_multi_stopwatch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the multi-channel BCD stopwatch.
package stopwatch_pkg;

    // Per-channel stopwatch state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPLIT = 2'd2,
        ST_PAUSE = 2'd3
    } ch_state_t;

    // Width of one BCD digit
    localparam int BCD_W      = 4;
    // Widest supported channel value; narrower channels use the low digits
    localparam int MAX_DIGITS = 8;
    localparam int MAX_VW     = BCD_W * MAX_DIGITS;

    typedef struct packed {
        logic              wrap;
        logic [MAX_VW-1:0] value;
    } bcd_inc_t;

    // Increment the low 'digits' BCD digits of value; wrap is set when all were 9
    function automatic bcd_inc_t bcd_inc(input logic [MAX_VW-1:0] value, input int digits);
        bcd_inc_t r;
        logic     carry;
        r.value = value;
        carry   = 1'b1;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            if (d < digits && carry) begin
                if (value[d*BCD_W +: BCD_W] == 4'd9) begin
                    r.value[d*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    r.value[d*BCD_W +: BCD_W] = value[d*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        r.wrap = carry;
        return r;
    endfunction

endpackage

// File: rtl/sw_channel.sv
// One stopwatch channel: state machine, BCD counter and split freeze register.
module sw_channel
    import stopwatch_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int VW     = BCD_W * DIGITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          trig,
    input  logic          split,
    input  logic          clear,
    output logic          running,
    output logic [VW-1:0] count,
    output logic [VW-1:0] disp_next
);

    ch_state_t         state_q, state_d;
    // Held at package width; the digits above DIGITS are never incremented and stay zero
    logic [MAX_VW-1:0] count_q, count_d;
    logic [VW-1:0]     frz_q, frz_d;
    logic              running_q;
    bcd_inc_t          inc;

    // State, count, freeze and running flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            frz_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            frz_q     <= frz_d;
            running_q <= (state_d == ST_RUN) || (state_d == ST_SPLIT);
        end
    end

    // Next state and count; clear beats trig beats split, counting follows the current state
    always_comb begin
        state_d = state_q;
        frz_d   = frz_q;
        count_d = count_q;
        inc     = bcd_inc(count_q, DIGITS);
        if (tick && (state_q == ST_RUN || state_q == ST_SPLIT))
            count_d = inc.wrap ? '0 : inc.value;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (trig) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_SPLIT: state_d = ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end else if (split) begin
            if (state_q == ST_RUN) begin
                state_d = ST_SPLIT;
                frz_d   = count_q[VW-1:0];
            end else if (state_q == ST_SPLIT) begin
                state_d = ST_RUN;
            end
        end
        disp_next = (state_d == ST_SPLIT) ? frz_d : count_d[VW-1:0];
    end

    assign running = running_q;
    assign count   = count_q[VW-1:0];

endmodule

// File: rtl/multi_stopwatch.sv
// N-channel stopwatch core: shared prescaler, channel select, lap buffer, output registers.
module multi_stopwatch
    import stopwatch_pkg::*;
#(
    parameter  int NUM_CH    = 2,
    parameter  int DIGITS    = 4,
    parameter  int TICK_DIV  = 1_000_000,
    parameter  int LAP_DEPTH = 4,
    localparam int VW        = BCD_W * DIGITS,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LCW       = $clog2(LAP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic              split,
    input  logic              clear,
    input  logic              toggle,
    input  logic              lap,
    input  logic              lap_next,
    output logic [CW-1:0]     sel,
    output logic [NUM_CH-1:0] sel_onehot,
    output logic [NUM_CH-1:0] running,
    output logic [VW-1:0]     disp_value,
    output logic [VW-1:0]     lap_value,
    output logic [CW-1:0]     lap_ch,
    output logic [LCW-1:0]    lap_count
);

    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW  = $clog2(LAP_DEPTH);

    logic [PSW-1:0]    presc_q;
    logic              tick;
    logic [CW-1:0]     sel_q, sel_d;
    logic [NUM_CH-1:0] onehot_q;
    logic [VW-1:0]     disp_q, disp_d;
    logic [VW-1:0]     live_count;
    logic [VW-1:0]     ch_count  [NUM_CH];
    logic [VW-1:0]     ch_disp   [NUM_CH];
    logic [NUM_CH-1:0] ch_run;

    logic [VW-1:0]     lap_val_mem [LAP_DEPTH];
    logic [CW-1:0]     lap_ch_mem  [LAP_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     age_q, age_d;
    logic [PW-1:0]     rd_idx;
    logic [LCW-1:0]    lap_cnt_q, lap_cnt_d;
    logic [VW-1:0]     lap_val_q, lap_val_d;
    logic [CW-1:0]     lap_ch_q, lap_ch_d;

    assign tick = (presc_q == PSW'(TICK_DIV - 1));

    // Channels see buttons only while selected; the tick is shared by all
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sw_channel #(.DIGITS(DIGITS)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .trig      (trig  && (sel_q == CW'(i))),
            .split     (split && (sel_q == CW'(i))),
            .clear     (clear && (sel_q == CW'(i))),
            .running   (ch_run[i]),
            .count     (ch_count[i]),
            .disp_next (ch_disp[i])
        );
    end

    // Select advance and output muxes; buttons act on the pre-toggle channel
    always_comb begin
        sel_d = sel_q;
        if (toggle)
            sel_d = (sel_q == CW'(NUM_CH - 1)) ? '0 : sel_q + CW'(1);
        disp_d     = '0;
        live_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_d == CW'(i)) disp_d     = ch_disp[i];
            if (sel_q == CW'(i)) live_count = ch_count[i];
        end
    end

    // Lap pointers and read-out; age counts back from the newest entry
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        lap_cnt_d = lap_cnt_q;
        age_d     = age_q;
        lap_val_d = lap_val_q;
        lap_ch_d  = lap_ch_q;
        rd_idx    = '0;
        if (lap) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (lap_cnt_q != LCW'(LAP_DEPTH))
                lap_cnt_d = lap_cnt_q + LCW'(1);
            age_d     = '0;
            lap_val_d = live_count;
            lap_ch_d  = sel_q;
        end else if (lap_next && lap_cnt_q != '0) begin
            if (LCW'(age_q) + LCW'(1) == lap_cnt_q)
                age_d = '0;
            else
                age_d = age_q + PW'(1);
            rd_idx    = wr_ptr_q - PW'(1) - age_d;
            lap_val_d = lap_val_mem[rd_idx];
            lap_ch_d  = lap_ch_mem[rd_idx];
        end
    end

    // Prescaler, select and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            sel_q     <= '0;
            onehot_q  <= NUM_CH'(1);
            disp_q    <= '0;
            wr_ptr_q  <= '0;
            age_q     <= '0;
            lap_cnt_q <= '0;
            lap_val_q <= '0;
            lap_ch_q  <= '0;
        end else begin
            presc_q   <= tick ? '0 : presc_q + PSW'(1);
            sel_q     <= sel_d;
            onehot_q  <= NUM_CH'(1) << sel_d;
            disp_q    <= disp_d;
            wr_ptr_q  <= wr_ptr_d;
            age_q     <= age_d;
            lap_cnt_q <= lap_cnt_d;
            lap_val_q <= lap_val_d;
            lap_ch_q  <= lap_ch_d;
        end
    end

    // Lap storage written at the write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LAP_DEPTH; k++) begin
                lap_val_mem[k] <= '0;
                lap_ch_mem[k]  <= '0;
            end
        end else if (lap) begin
            lap_val_mem[wr_ptr_q] <= live_count;
            lap_ch_mem[wr_ptr_q]  <= sel_q;
        end
    end

    assign sel        = sel_q;
    assign sel_onehot = onehot_q;
    assign running    = ch_run;
    assign disp_value = disp_q;
    assign lap_value  = lap_val_q;
    assign lap_ch     = lap_ch_q;
    assign lap_count  = lap_cnt_q;

endmodule

// File: tb/tb_multi_stopwatch.sv
// Scoreboard bench for multi_stopwatch with a behavioural reference model.
module tb_multi_stopwatch;

    localparam int NUM_CH = 3, DIGITS = 4, TICK_DIV = 4, LAP_DEPTH = 4;
    localparam int MODV = 10000;
    localparam int M_IDLE = 0, M_RUN = 1, M_SPLIT = 2, M_PAUSE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic trig = 0, split = 0, clear = 0, toggle = 0, lap = 0, lap_next = 0;
    logic [1:0]  sel;
    logic [2:0]  sel_onehot, running;
    logic [15:0] disp_value, lap_value;
    logic [1:0]  lap_ch;
    logic [2:0]  lap_count;

    // Small second instance for counter wrap-around
    logic       s_trig = 0, s_split = 0, s_clear = 0, s_toggle = 0, s_lap = 0, s_lap_next = 0;
    logic [0:0] s_sel, s_lap_ch;
    logic [1:0] s_sel_onehot, s_running, s_lap_count;
    logic [7:0] s_disp_value, s_lap_value;

    always #5 clk = ~clk;

    multi_stopwatch #(.NUM_CH(NUM_CH), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk(clk), .reset(reset), .trig(trig), .split(split), .clear(clear), .toggle(toggle),
        .lap(lap), .lap_next(lap_next), .sel(sel), .sel_onehot(sel_onehot), .running(running),
        .disp_value(disp_value), .lap_value(lap_value), .lap_ch(lap_ch), .lap_count(lap_count)
    );

    multi_stopwatch #(.NUM_CH(2), .DIGITS(2), .TICK_DIV(2), .LAP_DEPTH(2)) dut_small (
        .clk(clk), .reset(reset), .trig(s_trig), .split(s_split), .clear(s_clear), .toggle(s_toggle),
        .lap(s_lap), .lap_next(s_lap_next), .sel(s_sel), .sel_onehot(s_sel_onehot), .running(s_running),
        .disp_value(s_disp_value), .lap_value(s_lap_value), .lap_ch(s_lap_ch), .lap_count(s_lap_count)
    );

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;
    bit last_tick;

    typedef struct { int ch; int val; } lap_t;
    typedef struct {
        logic [1:0] sel; logic [2:0] onehot; logic [2:0] run; logic [15:0] disp;
        logic [15:0] lval; logic [1:0] lch; logic [2:0] lcnt;
    } exp_t;

    int   m_ps, m_sel, m_age;
    int   m_st [NUM_CH];
    int   m_cnt[NUM_CH];
    int   m_frz[NUM_CH];
    lap_t m_laps[$];
    exp_t sb[$];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ps = 0; m_sel = 0; m_age = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_frz[i] = 0;
        end
        m_laps.delete();
    endtask

    task automatic model_edge(input bit t, input bit sp, input bit cl, input bit tg, input bit lp, input bit ln);
        bit tk;
        int s;
        int old[NUM_CH];
        tk = (m_ps == TICK_DIV - 1);
        m_ps = tk ? 0 : m_ps + 1;
        last_tick = tk;
        s = m_sel;
        for (int i = 0; i < NUM_CH; i++) old[i] = m_cnt[i];
        for (int i = 0; i < NUM_CH; i++) begin
            if (tk && (m_st[i] == M_RUN || m_st[i] == M_SPLIT)) m_cnt[i] = (m_cnt[i] + 1) % MODV;
            if (i == s) begin
                if (cl) begin
                    m_st[i] = M_IDLE; m_cnt[i] = 0;
                end else if (t) begin
                    m_st[i] = (m_st[i] == M_IDLE || m_st[i] == M_PAUSE) ? M_RUN : M_PAUSE;
                end else if (sp) begin
                    if (m_st[i] == M_RUN) begin m_st[i] = M_SPLIT; m_frz[i] = old[i]; end
                    else if (m_st[i] == M_SPLIT) m_st[i] = M_RUN;
                end
            end
        end
        if (lp) begin
            m_laps.push_back('{ch: s, val: old[s]});
            if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_front());
            m_age = 0;
        end else if (ln && m_laps.size() > 0) begin
            m_age = (m_age + 1) % m_laps.size();
        end
        if (tg) m_sel = (m_sel + 1) % NUM_CH;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int n;
        e.sel = 2'(m_sel);
        e.onehot = 3'(1 << m_sel);
        for (int i = 0; i < NUM_CH; i++) e.run[i] = (m_st[i] == M_RUN || m_st[i] == M_SPLIT);
        e.disp = (m_st[m_sel] == M_SPLIT) ? to_bcd(m_frz[m_sel]) : to_bcd(m_cnt[m_sel]);
        n = m_laps.size();
        e.lcnt = 3'(n);
        if (n == 0) begin
            e.lval = '0; e.lch = '0;
        end else begin
            e.lval = to_bcd(m_laps[n-1-m_age].val);
            e.lch  = 2'(m_laps[n-1-m_age].ch);
        end
        return e;
    endfunction

    // Drive one cycle of buttons and queue the expected outputs after the edge
    task automatic step(input bit t, input bit sp, input bit cl, input bit tg, input bit lp, input bit ln);
        @(negedge clk);
        trig = t; split = sp; clear = cl; toggle = tg; lap = lp; lap_next = ln;
        model_edge(t, sp, cl, tg, lp, ln);
        sb.push_back(model_out());
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            idle();
            if (last_tick) seen++;
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},       32'(sel),        32'h0);
        chk({tag, "_onehot"},    32'(sel_onehot), 32'h1);
        chk({tag, "_running"},   32'(running),    32'h0);
        chk({tag, "_disp"},      32'(disp_value), 32'h0);
        chk({tag, "_lap_value"}, 32'(lap_value),  32'h0);
        chk({tag, "_lap_ch"},    32'(lap_ch),     32'h0);
        chk({tag, "_lap_count"}, 32'(lap_count),  32'h0);
    endtask

    // Monitor: every clock edge while enabled, pop the expected outputs and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: output presented with no expected entry");
                end else begin
                    e = sb.pop_front();
                    if (sel !== e.sel || sel_onehot !== e.onehot || running !== e.run ||
                        disp_value !== e.disp || lap_value !== e.lval || lap_ch !== e.lch ||
                        lap_count !== e.lcnt) begin
                        fails++;
                        $display("FAIL cycle_out: got sel=%0d oh=%b run=%b disp=%h lap=%h ch=%0d cnt=%0d, expected sel=%0d oh=%b run=%b disp=%h lap=%h ch=%0d cnt=%0d",
                                 sel, sel_onehot, running, disp_value, lap_value, lap_ch, lap_count,
                                 e.sel, e.onehot, e.run, e.disp, e.lval, e.lch, e.lcnt);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        logic [15:0] exp_laps[4];
        exp_laps[0] = 16'h0004; exp_laps[1] = 16'h0003; exp_laps[2] = 16'h0002; exp_laps[3] = 16'h0005;

        // Reset values
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #3;
        reset = 1'b1;
        model_reset();
        mon_en = 1;

        // Start, ten ticks, stop
        step(1, 0, 0, 0, 0, 0);
        wait_ticks(10);
        sample();
        chk("run_after_trig", 32'(running), 32'h1);
        chk("disp_10_ticks", 32'(disp_value), 32'h0010);
        step(1, 0, 0, 0, 0, 0);
        sample();
        chk("run_after_stop", 32'(running), 32'h0);
        wait_ticks(2);
        sample();
        chk("disp_held", 32'(disp_value), 32'h0010);

        // Split freeze and release
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        wait_ticks(5);
        step(0, 1, 0, 0, 0, 0);
        wait_ticks(3);
        sample();
        chk("split_frozen", 32'(disp_value), 32'h0005);
        step(0, 1, 0, 0, 0, 0);
        sample();
        chk("split_release", 32'(disp_value), 32'h0008);

        // Two channels running, select back on ch0
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        sample();
        chk("multi_sel", 32'(sel), 32'h0);
        chk("multi_onehot", 32'(sel_onehot), 32'h1);
        chk("multi_running", 32'(running), 32'h5);
        chk("multi_disp_ch0", 32'(disp_value), 32'(to_bcd(m_cnt[0])));

        // Clear on the same edge as a tick
        for (int i = 0; i < TICK_DIV && m_ps != TICK_DIV - 1; i++) idle();
        step(0, 0, 1, 0, 0, 0);
        sample();
        chk("clear_tick_disp", 32'(disp_value), 32'h0);
        chk("clear_tick_run", 32'(running[0]), 32'h0);

        // Five laps at counts 1..5, then walk the buffer
        step(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_ticks(1);
            step(0, 0, 0, 0, 1, 0);
        end
        sample();
        chk("lap_count_sat", 32'(lap_count), 32'h4);
        chk("lap_newest", 32'(lap_value), 32'h0005);
        chk("lap_ch", 32'(lap_ch), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1);
            sample();
            chk($sformatf("lap_next_%0d", k), 32'(lap_value), 32'(exp_laps[k]));
        end

        // trig with split from RUN pauses
        step(1, 1, 0, 0, 0, 0);
        sample();
        chk("trig_split_pause", 32'(running[0]), 32'h0);

        // Asynchronous reset while counting with laps stored
        step(1, 0, 0, 0, 0, 0);
        idle();
        idle();
        @(posedge clk); #3;
        mon_en = 0;
        trig = 0; split = 0; clear = 0; toggle = 0; lap = 0; lap_next = 0;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        mon_en = 1;
        step(1, 0, 0, 0, 0, 0);
        idle();
        idle();
        sample();
        chk("presc_restart_pre", 32'(disp_value), 32'h0);
        idle();
        sample();
        chk("presc_restart_first", 32'(disp_value), 32'h0001);

        // Randomized traffic
        repeat (3000) begin
            step($urandom_range(9) == 0, $urandom_range(7) == 0, $urandom_range(39) == 0,
                 $urandom_range(11) == 0, $urandom_range(9) == 0, $urandom_range(5) == 0);
        end
        @(posedge clk); #3;
        mon_en = 0;
        trig = 0; split = 0; clear = 0; toggle = 0; lap = 0; lap_next = 0;

        // Wrap-around on the two-digit instance
        @(negedge clk); s_trig = 1;
        @(negedge clk); s_trig = 0;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk); #2;
            if (s_disp_value == 8'h99) done = 1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL wrap_timeout: disp=%h, expected to reach 99", s_disp_value);
        end else begin
            chk("wrap_pre_run", 32'(s_running), 32'h1);
            @(posedge clk); #2;
            chk("wrap_hold", 32'(s_disp_value), 32'h99);
            @(posedge clk); #2;
            chk("wrap_zero", 32'(s_disp_value), 32'h00);
            chk("wrap_running", 32'(s_running), 32'h1);
            @(negedge clk);
            @(negedge clk); s_clear = 1;
            @(posedge clk); #2;
            chk("small_clear_tick_disp", 32'(s_disp_value), 32'h00);
            chk("small_clear_tick_run", 32'(s_running), 32'h0);
            @(negedge clk); s_clear = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
